ula_port: RTL and testbench
===========================

# ula_port

Parametrised successor to the ULA's port-0xFE logic. It decodes even-port writes to hold the border colour and EAR/MIC bits, and drives a saturating multi-source PCM beeper mix. It serves even-port reads from a registered keyboard matrix and a synchronised, glitch-filtered tape input. It also generates the frame interrupt from its own T-state frame counter. It sits between the CPU bus and the video, audio (I2S) and keyboard blocks, clocked by the CPU clock.

## Interface
Parameters:
- PCM_W, 16: PCM sample width (signed).
- EAR_AMP, 16384: mix contribution of EAR (D[4]) when set.
- MIC_AMP, 8192: mix contribution of MIC (D[3]) when set.
- TAPE_AMP, 4096: mix contribution of filtered tape input when set and tape_mon=1.
- TAPE_FILT, 4: consecutive stable cycles required before the filtered tape level changes (>=1).
- FRAME_LEN, 69888: clk cycles (T-states) per frame.
- INT_LEN, 32: cycles nintr is held low per frame (1..FRAME_LEN-1).

Ports:
- clk  in  1  CPU clock (T-state rate); the only clock.
- reset  in  1  synchronous, active-high reset.
- A  in  16  CPU address bus.
- D  in  8  CPU data bus (write data).
- io_we  in  1  I/O write strobe, sampled on clk.
- ula_data  out  8  read data for the current I/O address.
- key_matrix  in  40  active-low keys; bits [5r+4:5r] = half-row r, r=0..7.
- tape_in  in  1  raw tape level (asynchronous).
- tape_mon  in  1  enables tape monitoring in the PCM mix.
- border  out  3  border colour index.
- pcm_out  out  PCM_W  mixed beeper sample.
- nintr  out  1  active-low frame interrupt.
- frame_pos  out  17  current T-state within the frame.

## Operation
- Write decode: on a clk edge with io_we=1, A[0]=0 and reset=0:
  - border <= D[2:0]
  - mic <= D[3]
  - ear <= D[4]
- Writes with A[0]=1 are ignored.
- Keyboard: key_matrix is registered once per clk into krow.
  - A row r is selected when A[8+r]=0.
  - cols = bitwise AND of the selected krow entries; no row selected -> 5'h1F.
- Read data (combinational from registered state):
  - A[0]=0: ula_data = {1'b1, tape_f, 1'b1, cols}.
  - A[0]=1: ula_data = 8'hFF.
- Tape path: 2-flop synchroniser, then the tape_filter sub-module.
  - The filter counts consecutive cycles in which the synchronised level differs from tape_f.
  - On reaching TAPE_FILT, tape_f flips and the count clears.
  - Any cycle where the level equals tape_f clears the count.
- PCM mix: pcm_out <= sat(EAR_AMP*ear + MIC_AMP*mic + TAPE_AMP*(tape_f & tape_mon)).
  - The sum uses PCM_W+2 bits.
  - Saturation clamps to 2^(PCM_W-1)-1; the result is never negative.
  - Registered; updates every cycle.
- Frame timer: cnt counts 0..FRAME_LEN-1 and wraps to 0.
  - frame_pos = cnt.
  - nintr <= ~(cnt_next < INT_LEN), registered.

## Timing
- Reset values:
  - border=0, ear=0, mic=0, pcm_out=0
  - tape_f=0, filter count=0, synchroniser flops=0, krow=all 1s
  - cnt=FRAME_LEN-1, nintr=1
- Register write latency: border changes on the edge that samples the write. pcm_out reflects it one edge later.
- Key latency: a key_matrix change is visible on ula_data after 1 edge.
- Tape latency: tape_in change to tape_f = 2 (sync) + TAPE_FILT edges. A pulse shorter than TAPE_FILT cycles (post-sync) is rejected.
- Interrupt timing:
  - The first edge after reset release gives cnt=0 and nintr=0.
  - nintr stays low for exactly INT_LEN edges and is high for the remaining FRAME_LEN-INT_LEN.
  - The period is exactly FRAME_LEN.
- Reset mid-frame or mid-filter restores all reset values on that edge. The frame restarts on release.
- A simultaneous write and read in the same cycle: ula_data is unaffected, since the read content is independent of written state.

## Structure
- Package ula_pkg holds:
  - FRAME_LEN_48K=69888
  - INT_LEN_48K=32
  - port byte bit positions: BORDER_LSB=0, MIC_BIT=3, EAR_BIT=4, TAPE_RD_BIT=6
  - KEY_ROWS=8, KEY_COLS=5
- Sub-module tape_filter (params TAPE_FILT; ports clk, reset, din, dout) holds the synchroniser and the stability counter.
- Top level: write decode, krow register, read mux, PCM mixer, frame counter.

## Test plan
- Reset, then write A=16'h00FE, D=8'h1D -> border=5 next edge; pcm_out=24576 one edge later; write with A=16'h00FF -> no change.
- key_matrix bit 0 (row 0) low, read A=16'hFEFE -> ula_data=8'hBE after 1 edge; A=16'h7FFE -> 8'hBF; A=16'hFFFF -> 8'hFF.
- tape_in high for 3 cycles then low (TAPE_FILT=4) -> tape_f stays 0. Held high -> tape_f=1 exactly 6 edges later and ula_data[6]=1.
- ear=mic=1, tape_f=1, tape_mon=1 with PCM_W=15 -> pcm_out saturates at 16383.
- After reset release: nintr low on edges 1..32, high until edge 69888, low again at edge 69889. Reset asserted at cnt=1000 -> nintr=1 and frame restarts.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared constants and types for the ULA port-0xFE block: 48K frame timing,
// port byte bit positions and keyboard matrix geometry.
package ula_pkg;

  localparam int FRAME_LEN_48K = 69888;
  localparam int INT_LEN_48K   = 32;

  localparam int BORDER_LSB  = 0;
  localparam int MIC_BIT     = 3;
  localparam int EAR_BIT     = 4;
  localparam int TAPE_RD_BIT = 6;

  localparam int KEY_ROWS = 8;
  localparam int KEY_COLS = 5;

  typedef logic [KEY_COLS-1:0]          key_cols_t;
  typedef logic [KEY_ROWS*KEY_COLS-1:0] key_matrix_t;

endpackage

// File: rtl/tape_filter.sv
// Tape input conditioning: two-flop synchroniser followed by a stability
// counter, so the output only follows levels held for TAPE_FILT cycles.
module tape_filter #(
  parameter int TAPE_FILT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = (TAPE_FILT < 2) ? 1 : $clog2(TAPE_FILT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TAPE_FILT - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
      // A disagreeing sample extends the run; the last one in the run flips the level.
      if (sync2_reg != level_reg) begin
        if (count_reg == CNT_LAST) begin
          level_reg <= ~level_reg;
          count_reg <= '0;
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end else begin
        count_reg <= '0;
      end
    end
  end

  assign dout = level_reg;

endmodule

// File: rtl/ula_port.sv
// Port-0xFE logic: border/EAR/MIC write decode, keyboard and tape read-back,
// saturating beeper PCM mix and the frame interrupt timer.
module ula_port
  import ula_pkg::*;
#(
  parameter int PCM_W     = 16,
  parameter int EAR_AMP   = 16384,
  parameter int MIC_AMP   = 8192,
  parameter int TAPE_AMP  = 4096,
  parameter int TAPE_FILT = 4,
  parameter int FRAME_LEN = FRAME_LEN_48K,
  parameter int INT_LEN   = INT_LEN_48K
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             A,
  input  logic [7:0]              D,
  input  logic                    io_we,
  output logic [7:0]              ula_data,
  input  logic [39:0]             key_matrix,
  input  logic                    tape_in,
  input  logic                    tape_mon,
  output logic [2:0]              border,
  output logic signed [PCM_W-1:0] pcm_out,
  output logic                    nintr,
  output logic [16:0]             frame_pos
);

  localparam int SW = PCM_W + 2;
  localparam logic [SW-1:0] EAR_C   = SW'(EAR_AMP);
  localparam logic [SW-1:0] MIC_C   = SW'(MIC_AMP);
  localparam logic [SW-1:0] TAPE_C  = SW'(TAPE_AMP);
  localparam logic [SW-1:0] PCM_MAX = SW'((1 << (PCM_W - 1)) - 1);
  localparam logic [16:0] FRAME_LAST = 17'(FRAME_LEN - 1);
  localparam logic [16:0] INT_C      = 17'(INT_LEN);

  logic [2:0]       border_reg;
  logic             ear_reg;
  logic             mic_reg;
  key_matrix_t      krow_reg;
  logic [PCM_W-1:0] pcm_reg;
  logic [16:0]      cnt_reg;
  logic [16:0]      cnt_next;
  logic             nintr_reg;
  logic             tape_f;
  logic             wr_en;
  logic [SW-1:0]    mix_sum;
  logic [PCM_W-1:0] pcm_next;
  key_cols_t        row_sel [KEY_ROWS];
  key_cols_t        cols;
  logic             unused_bits;

  assign unused_bits = &{1'b0, A[7:1], D[7:5]};

  tape_filter #(
    .TAPE_FILT(TAPE_FILT)
  ) u_tape_filter (
    .clk  (clk),
    .reset(reset),
    .din  (tape_in),
    .dout (tape_f)
  );

  assign wr_en = io_we & ~A[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      border_reg <= '0;
      ear_reg    <= 1'b0;
      mic_reg    <= 1'b0;
      krow_reg   <= '1;
    end else begin
      krow_reg <= key_matrix;
      if (wr_en) begin
        border_reg <= D[BORDER_LSB +: 3];
        mic_reg    <= D[MIC_BIT];
        ear_reg    <= D[EAR_BIT];
      end
    end
  end

  // A deselected half-row contributes all ones, so no selection reads as 5'h1F.
  for (genvar gi = 0; gi < KEY_ROWS; gi++) begin : g_row
    assign row_sel[gi] = A[8+gi] ? '1 : krow_reg[gi*KEY_COLS +: KEY_COLS];
  end

  always_comb begin
    cols = '1;
    for (int r = 0; r < KEY_ROWS; r++) begin
      cols = cols & row_sel[r];
    end
  end

  always_comb begin
    ula_data = 8'hFF;
    if (!A[0]) begin
      ula_data[TAPE_RD_BIT]    = tape_f;
      ula_data[KEY_COLS-1:0]   = cols;
    end
  end

  // All sources are non-negative, so only the upper clamp is ever needed.
  always_comb begin
    mix_sum = (ear_reg ? EAR_C : '0)
            + (mic_reg ? MIC_C : '0)
            + ((tape_f & tape_mon) ? TAPE_C : '0);
    pcm_next = (mix_sum > PCM_MAX) ? PCM_MAX[PCM_W-1:0] : mix_sum[PCM_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcm_reg <= '0;
    end else begin
      pcm_reg <= pcm_next;
    end
  end

  assign cnt_next = (cnt_reg == FRAME_LAST) ? 17'd0 : cnt_reg + 17'd1;

  // Reset parks the counter on the last T-state so release starts a fresh frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= FRAME_LAST;
      nintr_reg <= 1'b1;
    end else begin
      cnt_reg   <= cnt_next;
      nintr_reg <= ~(cnt_next < INT_C);
    end
  end

  assign border    = border_reg;
  assign pcm_out   = pcm_reg;
  assign nintr     = nintr_reg;
  assign frame_pos = cnt_reg;

endmodule

// File: tb/tb_ula_port.sv
// Self-checking bench for ula_port: register writes, keyboard reads, tape
// filtering, PCM saturation and frame interrupt timing.
module tb_ula_port;

  localparam int FL = 69888;
  localparam int IL = 32;
  localparam int TAPE_FILT = 4;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        io_we;
  logic [39:0] keys;
  logic        tape_in;
  logic        tape_mon;

  logic [7:0]  ula_data;
  logic [2:0]  border;
  logic [15:0] pcm16;
  logic        nintr;
  logic [16:0] frame_pos;

  logic [7:0]  ula_data15;
  logic [2:0]  border15;
  logic [14:0] pcm15;
  logic        nintr15;
  logic [16:0] frame_pos15;

  int errors = 0;
  int checks = 0;

  bit  m_ear, m_mic, mf;
  int  run, tk;
  bit  th[$];

  ula_port dut (
    .clk(clk), .reset(reset), .A(addr), .D(data), .io_we(io_we),
    .ula_data(ula_data), .key_matrix(keys), .tape_in(tape_in), .tape_mon(tape_mon),
    .border(border), .pcm_out(pcm16), .nintr(nintr), .frame_pos(frame_pos)
  );

  ula_port #(.PCM_W(15)) dut15 (
    .clk(clk), .reset(reset), .A(addr), .D(data), .io_we(io_we),
    .ula_data(ula_data15), .key_matrix(keys), .tape_in(tape_in), .tape_mon(tape_mon),
    .border(border15), .pcm_out(pcm15), .nintr(nintr15), .frame_pos(frame_pos15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mix(bit e, bit m, bit t, int w);
    int s, mx;
    s  = (e ? 16384 : 0) + (m ? 8192 : 0) + (t ? 4096 : 0);
    mx = (1 << (w - 1)) - 1;
    return (s > mx) ? mx : s;
  endfunction

  function automatic logic [7:0] exp_read(logic [15:0] a, logic [39:0] k, logic tf);
    logic [4:0] c;
    if (a[0]) return 8'hFF;
    c = 5'h1F;
    for (int r = 0; r < 8; r++) if (!a[8+r]) c = c & k[5*r +: 5];
    return {1'b1, tf, 1'b1, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_ear = 1'b0;
    m_mic = 1'b0;
  endtask

  task automatic tape_model_init();
    mf = 1'b0;
    run = 0;
    tk = 0;
    th.delete();
  endtask

  // Advance one edge; the filter sees the raw level from two edges earlier.
  task automatic tape_step(output bit ef, output int p16, output int p15);
    bit lvl;
    p16 = mix(m_ear, m_mic, mf & tape_mon, 16);
    p15 = mix(m_ear, m_mic, mf & tape_mon, 15);
    tick();
    tk++;
    th.push_back(tape_in);
    lvl = (tk >= 3) ? th[tk-3] : 1'b0;
    if (lvl != mf) begin
      run++;
      if (run == TAPE_FILT) begin
        mf = ~mf;
        run = 0;
      end
    end else begin
      run = 0;
    end
    ef = mf;
  endtask

  task automatic test_reset();
    addr = 16'hFEFE; data = 8'h00; io_we = 1'b0; keys = '1; tape_in = 1'b0; tape_mon = 1'b0;
    do_reset();
    checks++; if (border !== 3'd0) begin errors++; $display("FAIL reset_border: got %0d want 0", border); end
    checks++; if (pcm16 !== 16'd0) begin errors++; $display("FAIL reset_pcm: got %0d want 0", pcm16); end
    checks++; if (pcm15 !== 15'd0) begin errors++; $display("FAIL reset_pcm15: got %0d want 0", pcm15); end
    checks++; if (nintr !== 1'b1) begin errors++; $display("FAIL reset_nintr: got %b want 1", nintr); end
    checks++; if (frame_pos !== 17'(FL-1)) begin errors++; $display("FAIL reset_frame_pos: got %0d want %0d", frame_pos, FL-1); end
    checks++; if (ula_data !== 8'hBF) begin errors++; $display("FAIL reset_read: got %h want bf", ula_data); end
    $display("reset done");
  endtask

  task automatic test_write();
    logic [15:0] a;
    logic [7:0]  d;
    logic [2:0]  mb;
    addr = 16'h00FE; data = 8'h1D; io_we = 1'b1;
    tick();
    io_we = 1'b0;
    checks++; if (border !== 3'd5) begin errors++; $display("FAIL wr_border: got %0d want 5", border); end
    checks++; if (ula_data !== 8'hBF) begin errors++; $display("FAIL wr_read_during_write: got %h want bf", ula_data); end
    tick();
    checks++; if (pcm16 !== 16'd24576) begin errors++; $display("FAIL wr_pcm: got %0d want 24576", pcm16); end
    checks++; if (pcm15 !== 15'd16383) begin errors++; $display("FAIL wr_pcm15: got %0d want 16383", pcm15); end
    m_ear = 1'b1; m_mic = 1'b1; mb = 3'd5;
    $display("write A=00fe D=1d border=%0d pcm=%0d", border, pcm16);
    addr = 16'h00FF; data = 8'h02; io_we = 1'b1;
    tick();
    io_we = 1'b0;
    tick();
    checks++; if (border !== 3'd5) begin errors++; $display("FAIL wr_odd_ignored: got %0d want 5", border); end
    checks++; if (pcm16 !== 16'd24576) begin errors++; $display("FAIL wr_odd_pcm: got %0d want 24576", pcm16); end
    $display("write A=00ff D=02 border=%0d pcm=%0d", border, pcm16);
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom); d = 8'($urandom);
      addr = a; data = d; io_we = 1'b1;
      tick();
      io_we = 1'b0;
      if (!a[0]) begin mb = d[2:0]; m_mic = d[3]; m_ear = d[4]; end
      checks++; if (border !== mb) begin errors++; $display("FAIL rnd_border: A=%h D=%h got %0d want %0d", a, d, border, mb); end
      checks++; if (ula_data !== exp_read(a, keys, 1'b0)) begin errors++; $display("FAIL rnd_wr_read: A=%h got %h want %h", a, ula_data, exp_read(a, keys, 1'b0)); end
      tick();
      checks++; if (pcm16 !== 16'(mix(m_ear, m_mic, 1'b0, 16))) begin errors++; $display("FAIL rnd_pcm: got %0d want %0d", pcm16, mix(m_ear, m_mic, 1'b0, 16)); end
      checks++; if (pcm15 !== 15'(mix(m_ear, m_mic, 1'b0, 15))) begin errors++; $display("FAIL rnd_pcm15: got %0d want %0d", pcm15, mix(m_ear, m_mic, 1'b0, 15)); end
      $display("write A=%h D=%h border=%0d pcm=%0d", a, d, border, pcm16);
    end
  endtask

  task automatic test_keys();
    logic [15:0] a;
    logic [39:0] k;
    io_we = 1'b0;
    keys = '1; tick();
    keys[0] = 1'b0; addr = 16'hFEFE;
    #1;
    checks++; if (ula_data !== 8'hBF) begin errors++; $display("FAIL key_latency: got %h want bf", ula_data); end
    tick();
    checks++; if (ula_data !== 8'hBE) begin errors++; $display("FAIL key_row0: got %h want be", ula_data); end
    addr = 16'h7FFE; #1;
    checks++; if (ula_data !== 8'hBF) begin errors++; $display("FAIL key_row7: got %h want bf", ula_data); end
    addr = 16'hFFFF; #1;
    checks++; if (ula_data !== 8'hFF) begin errors++; $display("FAIL key_odd: got %h want ff", ula_data); end
    $display("keys row0 bit0 pressed reads ok");
    for (int i = 0; i < 24; i++) begin
      k = 40'({$urandom(), $urandom()});
      a = 16'($urandom);
      if (i % 3 == 0) a[0] = 1'b0;
      keys = k; addr = a;
      tick();
      checks++; if (ula_data !== exp_read(a, k, 1'b0)) begin errors++; $display("FAIL rnd_key_read: A=%h K=%h got %h want %h", a, k, ula_data, exp_read(a, k, 1'b0)); end
      $display("read A=%h K=%h data=%h", a, k, ula_data);
    end
    keys = '1;
  endtask

  task automatic test_tape();
    bit ef;
    int p16, p15, len;
    addr = 16'h00FE; tape_in = 1'b0; tape_mon = 1'b0; keys = '1;
    do_reset();
    data = 8'h18; io_we = 1'b1;
    tick();
    io_we = 1'b0; m_ear = 1'b1; m_mic = 1'b1;
    tick(); tick();
    tape_model_init();
    tape_mon = 1'b1;
    // Short pulse must be rejected.
    tape_in = 1'b1;
    for (int s = 0; s < 11; s++) begin
      if (s == 3) tape_in = 1'b0;
      tape_step(ef, p16, p15);
      checks++; if (ula_data[6] !== 1'b0 || ef !== 1'b0) begin errors++; $display("FAIL tape_short_pulse: step %0d got %b want 0", s, ula_data[6]); end
    end
    tape_in = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      tape_step(ef, p16, p15);
      checks++; if (ula_data[6] !== (s == 6)) begin errors++; $display("FAIL tape_latency: step %0d got %b want %b", s, ula_data[6], s == 6); end
    end
    tape_step(ef, p16, p15);
    checks++; if (pcm16 !== 16'd28672) begin errors++; $display("FAIL tape_pcm_sum: got %0d want 28672", pcm16); end
    checks++; if (pcm15 !== 15'd16383) begin errors++; $display("FAIL tape_pcm_sat: got %0d want 16383", pcm15); end
    $display("tape level 1, pcm=%0d pcm15=%0d", pcm16, pcm15);
    tape_in = 1'b0;
    for (int s = 0; s < 8; s++) tape_step(ef, p16, p15);
    tape_in = 1'b1;
    for (int s = 0; s < 4; s++) tape_step(ef, p16, p15);
    reset = 1'b1;
    tick();
    reset = 1'b0; m_ear = 1'b0; m_mic = 1'b0;
    tape_model_init();
    checks++; if (ula_data[6] !== 1'b0) begin errors++; $display("FAIL tape_mid_reset: got %b want 0", ula_data[6]); end
    for (int s = 1; s <= 6; s++) begin
      tape_step(ef, p16, p15);
      checks++; if (ula_data[6] !== (s == 6)) begin errors++; $display("FAIL tape_after_reset: step %0d got %b want %b", s, ula_data[6], s == 6); end
    end
    $display("tape filter restarted after reset");
    data = 8'h10; io_we = 1'b1;
    tape_step(ef, p16, p15);
    io_we = 1'b0; m_ear = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tape_in = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        tape_mon = 1'($urandom_range(0, 1));
        tape_step(ef, p16, p15);
        checks++; if (ula_data[6] !== ef) begin errors++; $display("FAIL rnd_tape_f: edge %0d got %b want %b", tk, ula_data[6], ef); end
        checks++; if (pcm16 !== 16'(p16)) begin errors++; $display("FAIL rnd_tape_pcm: edge %0d got %0d want %0d", tk, pcm16, p16); end
        checks++; if (pcm15 !== 15'(p15)) begin errors++; $display("FAIL rnd_tape_pcm15: edge %0d got %0d want %0d", tk, pcm15, p15); end
      end
      $display("tape run level=%b len=%0d tape_f=%b pcm=%0d", tape_in, len, ula_data[6], pcm16);
    end
    tape_in = 1'b0; tape_mon = 1'b0;
  endtask

  task automatic test_interrupt();
    int pos;
    bit en;
    do_reset();
    for (int k = 1; k <= FL + 1000 + 1; k++) begin
      tick();
      pos = (k - 1) % FL;
      en = (pos >= IL);
      checks++;
      if (nintr !== en || frame_pos !== 17'(pos)) begin
        errors++;
        if (errors <= 30) $display("FAIL frame_timing: edge %0d got nintr=%b pos=%0d want nintr=%b pos=%0d", k, nintr, frame_pos, en, pos);
      end
    end
    $display("frame wrap seen, now at pos=%0d", frame_pos);
    checks++; if (frame_pos !== 17'd1000) begin errors++; $display("FAIL frame_pos_1000: got %0d want 1000", frame_pos); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (nintr !== 1'b1) begin errors++; $display("FAIL mid_reset_nintr: got %b want 1", nintr); end
    checks++; if (frame_pos !== 17'(FL-1)) begin errors++; $display("FAIL mid_reset_pos: got %0d want %0d", frame_pos, FL-1); end
    for (int k = 1; k <= 40; k++) begin
      tick();
      en = (k - 1 >= IL);
      checks++;
      if (nintr !== en || frame_pos !== 17'(k-1)) begin
        errors++;
        if (errors <= 60) $display("FAIL frame_restart: edge %0d got nintr=%b pos=%0d want nintr=%b pos=%0d", k, nintr, frame_pos, en, k-1);
      end
    end
    $display("frame restarted after mid-frame reset");
  endtask

  initial begin
    reset = 1'b1; addr = 16'hFEFE; data = 8'h00; io_we = 1'b0;
    keys = '1; tape_in = 1'b0; tape_mon = 1'b0;
    test_reset();
    test_write();
    test_keys();
    test_tape();
    test_interrupt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
